// File: rtl/stuffing_fd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : stuffing_fd
//  Description : Transmit bit stuffer: dynamic run-length stuffing plus
//                fixed-interval stuffing for the FD CRC field.
//  Revision    : 1.0 - initial release
// ============================================================================
module stuffing_fd #(
   parameter int RUNLEN = 5,
   parameter int FIXLEN = 4,
   parameter int CNTW   = 3
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            bitin,
   input  logic            activ,
   input  logic            direct,
   input  logic            setdom,
   input  logic            setrec,
   input  logic            fixed,
   input  logic            clrcnt,
   output logic            bitout,
   output logic            stuff,
   output logic            fixbit,
   output logic [CNTW-1:0] stuffcnt
);

   localparam logic [2:0] c_RUNLEN = 3'(RUNLEN);
   localparam logic [2:0] c_FIXLEN = 3'(FIXLEN);

   logic            r_activ_d;
   logic            r_last;
   logic            r_infix;
   logic [2:0]      r_cnt;
   logic [2:0]      r_fcnt;
   logic            r_bitout;
   logic            r_stuff;
   logic            r_fixbit;
   logic [CNTW-1:0] r_stuffcnt;

   logic            w_step;
   logic            w_dyn;
   logic [2:0]      w_cnt_eff;
   logic            w_dyn_stuff;

   assign w_step      = activ & ~r_activ_d;
   assign w_dyn       = ~direct & ~setdom & ~setrec & ~fixed;
   // Leaving fixed mode restarts run counting from scratch.
   assign w_cnt_eff   = r_infix ? 3'd0 : r_cnt;
   assign w_dyn_stuff = w_step & w_dyn & (w_cnt_eff == c_RUNLEN);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_activ_d  <= 1'b0;
         r_last     <= 1'b0;
         r_infix    <= 1'b0;
         r_cnt      <= 3'd0;
         r_fcnt     <= 3'd0;
         r_bitout   <= 1'b1;
         r_stuff    <= 1'b0;
         r_fixbit   <= 1'b0;
         r_stuffcnt <= '0;
      end else begin
         r_activ_d <= activ;
         if (w_step) begin
            if (direct) begin
               r_bitout <= bitin;
               r_stuff  <= 1'b0;
               r_fixbit <= 1'b0;
            end else if (setdom) begin
               r_bitout <= 1'b0;
               r_stuff  <= 1'b0;
               r_fixbit <= 1'b0;
            end else if (setrec) begin
               r_bitout <= 1'b1;
               r_stuff  <= 1'b0;
               r_fixbit <= 1'b0;
            end else if (fixed) begin
               if (!r_infix || (r_fcnt >= c_FIXLEN)) begin
                  r_bitout <= ~r_last;
                  r_stuff  <= 1'b1;
                  r_fixbit <= 1'b1;
                  r_last   <= ~r_last;
                  r_fcnt   <= 3'd0;
                  r_infix  <= 1'b1;
               end else begin
                  r_bitout <= bitin;
                  r_stuff  <= 1'b0;
                  r_fixbit <= 1'b0;
                  r_last   <= bitin;
                  r_fcnt   <= r_fcnt + 3'd1;
               end
            end else begin
               r_infix  <= 1'b0;
               r_fixbit <= 1'b0;
               if (w_cnt_eff == c_RUNLEN) begin
                  // bitin is held back; the MAC presents it again next step
                  r_bitout <= ~r_last;
                  r_stuff  <= 1'b1;
                  r_last   <= ~r_last;
                  r_cnt    <= 3'd1;
               end else if ((w_cnt_eff == 3'd0) || (bitin != r_last)) begin
                  r_bitout <= bitin;
                  r_stuff  <= 1'b0;
                  r_last   <= bitin;
                  r_cnt    <= 3'd1;
               end else begin
                  r_bitout <= bitin;
                  r_stuff  <= 1'b0;
                  r_cnt    <= r_cnt + 3'd1;
               end
            end
         end
         if (clrcnt) begin
            r_stuffcnt <= '0;
         end else if (w_dyn_stuff) begin
            r_stuffcnt <= r_stuffcnt + 1'b1;
         end
      end
   end

   assign bitout   = r_bitout;
   assign stuff    = r_stuff;
   assign fixbit   = r_fixbit;
   assign stuffcnt = r_stuffcnt;

endmodule
`default_nettype wire

// File: tb/tb_stuffing_fd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_stuffing_fd
//  Description : Scoreboard bench for stuffing_fd (RUNLEN=5, FIXLEN=4, CNTW=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stuffing_fd;

   logic       clock;
   logic       reset;
   logic       bitin;
   logic       activ;
   logic       direct;
   logic       setdom;
   logic       setrec;
   logic       fixed;
   logic       clrcnt;
   logic       bitout;
   logic       stuff;
   logic       fixbit;
   logic [2:0] stuffcnt;
   logic       clk_en;

   int n_err;
   int n_chk;

   typedef struct {
      string      tag;
      logic       bo;
      logic       st;
      logic       fb;
      logic [2:0] sc;
   } exp_t;

   exp_t sb_q[$];

   stuffing_fd #(.RUNLEN(5), .FIXLEN(4), .CNTW(3)) dut (
      .clock    (clock),
      .reset    (reset),
      .bitin    (bitin),
      .activ    (activ),
      .direct   (direct),
      .setdom   (setdom),
      .setrec   (setrec),
      .fixed    (fixed),
      .clrcnt   (clrcnt),
      .bitout   (bitout),
      .stuff    (stuff),
      .fixbit   (fixbit),
      .stuffcnt (stuffcnt)
   );

   initial begin
      clock = 1'b0;
      wait (clk_en);
      forever #5 clock = ~clock;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
      end
   endtask

   task automatic push(input string tag, input logic bo, input logic st, input logic fb,
                       input logic [2:0] sc);
      exp_t e;
      e.tag = tag;
      e.bo  = bo;
      e.st  = st;
      e.fb  = fb;
      e.sc  = sc;
      sb_q.push_back(e);
   endtask

   task automatic sb_check();
      exp_t e;
      if (sb_q.size() == 0) begin
         check("sb_empty", 32'(sb_q.size()), 32'd1);
      end else begin
         e = sb_q.pop_front();
         check({e.tag, ".bitout"},   32'(bitout),   32'(e.bo));
         check({e.tag, ".stuff"},    32'(stuff),    32'(e.st));
         check({e.tag, ".fixbit"},   32'(fixbit),   32'(e.fb));
         check({e.tag, ".stuffcnt"}, 32'(stuffcnt), 32'(e.sc));
      end
   endtask

   // Called just after a falling edge; returns just after a falling edge
   // with activ low again so the next call is a fresh step.
   task automatic step(input string tag, input logic b, input logic d, input logic dm,
                       input logic rc, input logic fx, input logic cc,
                       input logic ebo, input logic est, input logic efb,
                       input logic [2:0] esc);
      bitin  = b;
      direct = d;
      setdom = dm;
      setrec = rc;
      fixed  = fx;
      clrcnt = cc;
      activ  = 1'b1;
      push(tag, ebo, est, efb, esc);
      @(posedge clock);
      #1;
      sb_check();
      @(negedge clock);
      activ  = 1'b0;
      direct = 1'b0;
      setdom = 1'b0;
      setrec = 1'b0;
      fixed  = 1'b0;
      clrcnt = 1'b0;
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic dyn(input string tag, input logic b, input logic ebo, input logic est,
                      input logic [2:0] esc);
      step(tag, b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ebo, est, 1'b0, esc);
   endtask

   initial begin
      logic       lv;
      logic [2:0] sc_exp;
      n_err  = 0;
      n_chk  = 0;
      clk_en = 1'b0;
      reset  = 1'b1;
      activ  = 1'b1;
      bitin  = 1'b0;
      direct = 1'b0;
      setdom = 1'b0;
      setrec = 1'b0;
      fixed  = 1'b0;
      clrcnt = 1'b0;

      // reset without any clock edge
      #2 reset = 1'b0;
      #1;
      push("reset", 1'b1, 1'b0, 1'b0, 3'd0);
      sb_check();
      #2 reset  = 1'b1;
      clk_en = 1'b1;

      // activ held high through reset: first edge after release is a step
      dyn("post_rst", 1'b0, 1'b0, 1'b0, 3'd0);
      for (int i = 0; i < 4; i++) dyn("run0", 1'b0, 1'b0, 1'b0, 3'd0);
      dyn("stuff6", 1'b0, 1'b1, 1'b1, 3'd1);
      dyn("after_stuff", 1'b0, 1'b0, 1'b0, 3'd1);

      for (int i = 0; i < 12; i++) begin
         lv = ((i % 2) == 0);
         dyn("alt", lv, lv, 1'b0, 3'd1);
      end

      // activ held high: only the first edge steps, later bitin changes ignored
      bitin = 1'b0;
      activ = 1'b1;
      push("hold_first", 1'b0, 1'b0, 1'b0, 3'd1);
      @(posedge clock);
      #1;
      sb_check();
      bitin = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock);
         #1;
         push("hold_more", 1'b0, 1'b0, 1'b0, 3'd1);
         sb_check();
      end
      @(negedge clock);
      activ = 1'b0;
      bitin = 1'b0;
      @(posedge clock);
      @(negedge clock);

      // fixed stuffing with last=1
      dyn("set_last1", 1'b1, 1'b1, 1'b0, 3'd1);
      step("fix_entry", 1'b0, 0, 0, 0, 1, 0, 1'b0, 1'b1, 1'b1, 3'd1);
      step("fix_d1",    1'b1, 0, 0, 0, 1, 0, 1'b1, 1'b0, 1'b0, 3'd1);
      step("fix_d2",    1'b1, 0, 0, 0, 1, 0, 1'b1, 1'b0, 1'b0, 3'd1);
      step("fix_d3",    1'b0, 0, 0, 0, 1, 0, 1'b0, 1'b0, 1'b0, 3'd1);
      step("fix_d4",    1'b0, 0, 0, 0, 1, 0, 1'b0, 1'b0, 1'b0, 3'd1);
      step("fix_stuff", 1'b0, 0, 0, 0, 1, 0, 1'b1, 1'b1, 1'b1, 3'd1);
      dyn("fix_exit", 1'b1, 1'b1, 1'b0, 3'd1);

      // setdom in the middle of a run of 0s does not advance the run
      for (int i = 0; i < 4; i++) dyn("run_pre_dom", 1'b0, 1'b0, 1'b0, 3'd1);
      step("setdom", 1'b0, 0, 1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 3'd1);
      dyn("cnt5", 1'b0, 1'b0, 1'b0, 3'd1);
      dyn("stuff_dom", 1'b0, 1'b1, 1'b1, 3'd2);

      // direct / setrec and priority among step kinds
      step("direct",   1'b0, 1, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 3'd2);
      step("setrec",   1'b0, 0, 0, 1, 0, 0, 1'b1, 1'b0, 1'b0, 3'd2);
      dyn("post_rec", 1'b0, 1'b0, 1'b0, 3'd2);
      step("pri_all",  1'b1, 1, 1, 1, 1, 0, 1'b1, 1'b0, 1'b0, 3'd2);
      step("pri_dom",  1'b1, 0, 1, 1, 0, 0, 1'b0, 1'b0, 1'b0, 3'd2);
      step("pri_rec",  1'b0, 0, 0, 1, 1, 0, 1'b1, 1'b0, 1'b0, 3'd2);
      step("pri_dir",  1'b0, 1, 0, 0, 1, 0, 1'b0, 1'b0, 1'b0, 3'd2);

      // clrcnt alone, no step
      clrcnt = 1'b1;
      push("clr_only", 1'b0, 1'b0, 1'b0, 3'd0);
      @(posedge clock);
      #1;
      sb_check();
      @(negedge clock);
      clrcnt = 1'b0;

      // eight dynamic stuff events wrap the 3-bit counter back to 0
      lv     = 1'b0;
      sc_exp = 3'd0;
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < 4; i++) dyn("wrap_run", lv, lv, 1'b0, sc_exp);
         sc_exp = sc_exp + 3'd1;
         dyn("wrap_stuff", lv, ~lv, 1'b1, sc_exp);
         lv = ~lv;
      end

      // clrcnt coinciding with a stuff event
      for (int i = 0; i < 4; i++) dyn("clr_run", lv, lv, 1'b0, 3'd0);
      step("clr_stuff", lv, 0, 0, 0, 0, 1, ~lv, 1'b1, 1'b0, 3'd0);
      dyn("clr_after", lv, lv, 1'b0, 3'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
